syrup_mem_port_arbiter: RTL
===========================

// Module: syrup_mem_port_arbiter
// PURPOSE
//  Shares one SyrupMemory1P port among NUM_PORTS requesters in the same domain.
//  Round-robin arbitration with optional burst lock; registers the winning command onto the memory port.
//  Returns read data to the issuing requester after a fixed read latency.
//  Sits between user-logic sub-blocks and a single SyrupMemory1P instance.
// PARAMETERS
//  NUM_PORTS     4    requester count, 2..16
//  W_A           16   address width
//  W_D           32   data width
//  READ_LATENCY  1    cycles from MEM_RE registered high to MEM_Q valid, 1..4
//  MAX_LOCK      8    maximum consecutive grants to a locking port, >=1
// PORTS
//  CLK        in   1              clock
//  RST        in   1              synchronous, active-low reset (0 = reset)
//  REQ_VALID  in   NUM_PORTS      per-port command valid
//  REQ_READY  out  NUM_PORTS      per-port accept, one-hot or zero
//  REQ_WE     in   NUM_PORTS      per-port write (1) / read (0)
//  REQ_LOCK   in   NUM_PORTS      request grant retention for next cycle
//  REQ_ADDR   in   NUM_PORTS*W_A  packed addresses; port i at [i*W_A +: W_A]
//  REQ_D      in   NUM_PORTS*W_D  packed write data
//  REQ_BE     in   NUM_PORTS*W_D/8  packed byte enables
//  RSP_VALID  out  NUM_PORTS      read data valid, one-hot or zero
//  RSP_Q      out  W_D            read data, shared by all ports
//  MEM_ADDR   out  W_A            to SyrupMemory1P ADDR
//  MEM_D      out  W_D            to SyrupMemory1P D
//  MEM_WE     out  1              to SyrupMemory1P WE
//  MEM_RE     out  1              to SyrupMemory1P RE
//  MEM_BE     out  W_D/8          to SyrupMemory1P BE
//  MEM_Q      in   W_D            from SyrupMemory1P Q
// BEHAVIOUR
//  Reset: REQ_READY=0, RSP_VALID=0, MEM_WE=0, MEM_RE=0, MEM_ADDR/D/BE=0, priority ptr=0, lock cnt=0, state IDLE.
//  Transfer on REQ_VALID[i] & REQ_READY[i]. REQ_READY is combinational from REQ_VALID, ptr and state.
//  At most one bit of REQ_READY is high per cycle.
//  Round robin: search from ptr upward, wrapping NUM_PORTS-1 -> 0.
//  On a grant to port g, ptr <= (g+1) mod NUM_PORTS.
//  Issue latency 1: the accepted command appears on MEM_* the next cycle, for exactly one cycle.
//  MEM_RE = ~REQ_WE and MEM_WE = REQ_WE; MEM_RE and MEM_WE are never both high.
//  Idle cycle: MEM_WE = MEM_RE = 0, and MEM_ADDR/D/BE hold their last values.
//  Read return: the owner id passes through a READ_LATENCY-deep pipe.
//  RSP_VALID[owner] is high READ_LATENCY cycles after MEM_RE; RSP_Q = MEM_Q, passed through combinationally.
//  Reads are fully pipelined, so a port may issue one read every cycle.
//  States:
//   IDLE -> GRANT when any REQ_VALID.
//   GRANT: if the granted port had REQ_LOCK=1, -> LOCKED with lock cnt = 1; else stay GRANT, or -> IDLE if no valid.
//   LOCKED: only the lock owner may be granted, and the cnt increments on each grant.
//   Leave LOCKED -> GRANT when any of these holds: owner drops REQ_VALID; owner drops REQ_LOCK on its last beat; cnt == MAX_LOCK.
//   On leaving LOCKED, ptr points past the owner, so the owner cannot starve the others.
//  Reset mid-operation: in-flight reads are discarded (RSP_VALID stays 0), a LOCKED grant is released, and ptr returns to 0.
// CONFIGURATION
//  SYRUP_ARB_STATS_EN defined: adds STAT_SEL in [$clog2(NUM_PORTS)] and STAT_CNT out [31:0].
//   One 32-bit saturating grant counter per port, cleared by reset.
//   STAT_CNT = counter[STAT_SEL], registered, 1 cycle latency.
//  SYRUP_ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Shared header syrup_arb.vh: state encodings ARB_IDLE/ARB_GRANT/ARB_LOCKED, and the clog2 function.
//  Sub-module syrup_rr_pick: combinational one-hot round-robin pick (req, ptr, mask -> gnt, gnt_idx).
//  The top level holds the FSM, lock counter, command register, owner pipe and the optional stats.
// TESTING
//  1. Single port 0 read at addr 0x10, mem model returns 0xA5A5_0010 -> MEM_RE high the cycle after accept;
//     RSP_VALID[0] high READ_LATENCY cycles later, RSP_Q = 0xA5A5_0010.
//  2. All 4 ports valid continuously, no lock -> grant order 0,1,2,3,0,1,...; each port gets 1 grant per 4 cycles.
//  3. Port 2 with LOCK=1 and 12 back-to-back writes, others valid ->
//     exactly MAX_LOCK=8 consecutive grants to port 2, then port 3 granted.
//  4. Interleaved reads from ports 1 and 3, READ_LATENCY=3 ->
//     each RSP_VALID pulse goes to the correct port in issue order, with no cycle gaps.
//  5. RST=0 asserted 1 cycle after two reads are issued -> no RSP_VALID afterwards, MEM_RE=0, next grant goes to port 0.
//  6. SYRUP_ARB_STATS_EN defined, 10 grants to port 1 -> STAT_SEL=1 gives STAT_CNT=10 one cycle later; other ports read 0.

Source files
------------

// File: rtl/syrup_mem_port_arbiter_pkg.sv
// Shared definitions for syrup_mem_port_arbiter: FSM state encoding and a
// width helper used to size pointers, owner ids and the lock counter.
package syrup_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/syrup_mem_port_arbiter_rr_pick.sv
// syrup_rr_pick: combinational round-robin pick. Searches req & mask upward
// from ptr, wrapping at N-1, and returns a one-hot grant plus its index.
module syrup_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic         found;
  logic [W-1:0] idx;

  // First eligible requester at or after ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = W'((int'(ptr) + off) % N);
      if (!found && req[idx] && mask[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/syrup_mem_port_arbiter.sv
// syrup_mem_port_arbiter: shares one SyrupMemory1P port among NUM_PORTS
// requesters. Round-robin with optional burst lock, registered command issue
// and a READ_LATENCY-deep owner pipe that steers read data back.
// Optional feature macro: SYRUP_ARB_STATS_EN (per-port saturating grant counters).
module syrup_mem_port_arbiter
  import syrup_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int W_A          = 16,
  parameter int W_D          = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_LOCK     = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_PORTS-1:0]           REQ_VALID,
  output logic [NUM_PORTS-1:0]           REQ_READY,
  input  logic [NUM_PORTS-1:0]           REQ_WE,
  input  logic [NUM_PORTS-1:0]           REQ_LOCK,
  input  logic [NUM_PORTS*W_A-1:0]       REQ_ADDR,
  input  logic [NUM_PORTS*W_D-1:0]       REQ_D,
  input  logic [NUM_PORTS*(W_D/8)-1:0]   REQ_BE,
  output logic [NUM_PORTS-1:0]           RSP_VALID,
  output logic [W_D-1:0]                 RSP_Q,
  output logic [W_A-1:0]                 MEM_ADDR,
  output logic [W_D-1:0]                 MEM_D,
  output logic                           MEM_WE,
  output logic                           MEM_RE,
  output logic [W_D/8-1:0]               MEM_BE,
  input  logic [W_D-1:0]                 MEM_Q
`ifdef SYRUP_ARB_STATS_EN
  ,
  input  logic [clog2(NUM_PORTS)-1:0]    STAT_SEL,
  output logic [31:0]                    STAT_CNT
`endif
);

  localparam int PTR_W  = clog2(NUM_PORTS);
  localparam int LOCK_W = clog2(MAX_LOCK + 1);
  localparam int W_B    = W_D / 8;

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      lock_owner_q, lock_owner_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [W_A-1:0]        mem_addr_q, mem_addr_d;
  logic [W_D-1:0]        mem_d_q, mem_d_d;
  logic [W_B-1:0]        mem_be_q, mem_be_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [PTR_W-1:0]      cmd_owner_q, cmd_owner_d;
  logic                  pipe_vld_q [READ_LATENCY];
  logic                  pipe_vld_d [READ_LATENCY];
  logic [PTR_W-1:0]      pipe_idx_q [READ_LATENCY];
  logic [PTR_W-1:0]      pipe_idx_d [READ_LATENCY];

  logic [W_A-1:0]        req_addr_a [NUM_PORTS];
  logic [W_D-1:0]        req_d_a    [NUM_PORTS];
  logic [W_B-1:0]        req_be_a   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  lock_mask, pick_mask, pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  grant;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign req_addr_a[i] = REQ_ADDR[i*W_A +: W_A];
    assign req_d_a[i]    = REQ_D[i*W_D +: W_D];
    assign req_be_a[i]   = REQ_BE[i*W_B +: W_B];
  end

  // While locked only the owner is eligible; otherwise every port is.
  always_comb begin
    lock_mask               = '0;
    lock_mask[lock_owner_q] = 1'b1;
    pick_mask               = (state_q == ARB_LOCKED) ? lock_mask : '1;
  end

  syrup_rr_pick #(
    .N (NUM_PORTS),
    .W (PTR_W)
  ) u_pick (
    .req     (REQ_VALID),
    .ptr     (ptr_q),
    .mask    (pick_mask),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // No accept is offered while reset is held.
  assign REQ_READY = RST ? pick_gnt : '0;
  assign grant     = |REQ_READY;

  // Arbitration FSM, pointer, lock counter and the command register inputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_d_d      = mem_d_q;
    mem_be_d     = mem_be_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    cmd_owner_d  = cmd_owner_q;

    if (grant) begin
      ptr_d       = (pick_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
      mem_addr_d  = req_addr_a[pick_idx];
      mem_d_d     = req_d_a[pick_idx];
      mem_be_d    = req_be_a[pick_idx];
      mem_we_d    = REQ_WE[pick_idx];
      mem_re_d    = ~REQ_WE[pick_idx];
      cmd_owner_d = pick_idx;
    end

    case (state_q)
      ARB_IDLE, ARB_GRANT: begin
        if (grant && REQ_LOCK[pick_idx] && (MAX_LOCK > 1)) begin
          state_d      = ARB_LOCKED;
          lock_owner_d = pick_idx;
          lock_cnt_d   = LOCK_W'(1);
        end else if (|REQ_VALID) begin
          state_d = ARB_GRANT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (!grant) begin
          state_d    = ARB_GRANT;
          lock_cnt_d = '0;
        end else if (!REQ_LOCK[lock_owner_q] || lock_cnt_q == LOCK_W'(MAX_LOCK - 1)) begin
          state_d    = ARB_GRANT;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Owner pipe: one stage per cycle of memory read latency.
  always_comb begin
    pipe_vld_d[0] = mem_re_q;
    pipe_idx_d[0] = cmd_owner_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
  end

  // Steer returning data to the requester that issued the read.
  always_comb begin
    RSP_VALID = '0;
    if (RST && pipe_vld_q[READ_LATENCY-1]) begin
      RSP_VALID[pipe_idx_q[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign RSP_Q    = MEM_Q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_D    = mem_d_q;
  assign MEM_BE   = mem_be_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_RE   = mem_re_q;

  // State and command registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    if (!RST) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      mem_be_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      cmd_owner_q  <= '0;
      // NOTE: the owner pipe is reset element by element, because its valid
      // bits decide whether stale in-flight reads get reported after reset.
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_idx_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_d_q      <= mem_d_d;
      mem_be_q     <= mem_be_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      cmd_owner_q  <= cmd_owner_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_d[k];
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
    end
  end

`ifdef SYRUP_ARB_STATS_EN
  logic [31:0] stat_cnt_q [NUM_PORTS];
  logic [31:0] stat_cnt_d [NUM_PORTS];
  logic [31:0] stat_out_q, stat_out_d;

  // Saturating per-port grant counters and the registered read-out mux.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
    end
    if (grant && stat_cnt_q[pick_idx] != '1) begin
      stat_cnt_d[pick_idx] = stat_cnt_q[pick_idx] + 32'd1;
    end
    stat_out_d = stat_cnt_q[STAT_SEL];
  end

  // Counter storage, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        stat_cnt_q[i] <= '0;
      end
      stat_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        stat_cnt_q[i] <= stat_cnt_d[i];
      end
      stat_out_q <= stat_out_d;
    end
  end

  assign STAT_CNT = stat_out_q;
`endif

endmodule
